// File: rtl/sdram_port_arbiter_pkg.sv
// sdram_arb_pkg: shared FSM state type, port limit and round-robin pointer increment for the SDRAM port arbiter
package sdram_arb_pkg;
  localparam int MAX_PORTS = 8;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_LO, ST_WAIT_HI} state_t;
  function automatic logic [2:0] rr_next(input logic [2:0] ptr, input int n);
    return (int'(ptr) >= n - 1) ? 3'd0 : ptr + 3'd1;
  endfunction
endpackage

// File: rtl/sdram_rr_pick.sv
// sdram_rr_pick: combinational round-robin winner search (req, ptr, prio0 -> valid, idx)
module sdram_rr_pick import sdram_arb_pkg::*; #(
  parameter int NPORTS = 3,
  localparam int IW = $clog2(NPORTS)
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IW-1:0]     ptr,
  input  logic              prio0,
  output logic              valid,
  output logic [IW-1:0]     idx
);
  logic [NPORTS-1:0] rot;
  always_comb begin
    rot = NPORTS'({req, req} >> ptr);
    idx = '0;
    for (int k = NPORTS - 1; k >= 0; k--) if (rot[k]) idx = IW'((int'(ptr) + k) % NPORTS);
    if (prio0 && req[0]) idx = '0;
  end
  assign valid = |req;
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller among NPORTS level req/ack ports, one transaction in flight
//   p_*   : per-port req/we/addr/din/wtbt in, shared p_dout and one-hot p_ack pulse out
//   mem_* : controller addr/din/wtbt/we/rd out (we/rd are one-cycle pulses), dout/ready in
module sdram_port_arbiter import sdram_arb_pkg::*; #(
  parameter int NPORTS = 3,
  parameter int PRIO0  = 0,
  parameter int AW     = 27
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    p_req,
  input  logic [NPORTS-1:0]    p_we,
  input  logic [NPORTS*AW-1:0] p_addr,
  input  logic [NPORTS*16-1:0] p_din,
  input  logic [NPORTS*2-1:0]  p_wtbt,
  output logic [15:0]          p_dout,
  output logic [NPORTS-1:0]    p_ack,
  output logic [AW-1:0]        mem_addr,
  output logic [15:0]          mem_din,
  output logic [1:0]           mem_wtbt,
  output logic                 mem_we,
  output logic                 mem_rd,
  input  logic [15:0]          mem_dout,
  input  logic                 mem_ready
);
  localparam int IW = $clog2(NPORTS);
  state_t            state_q, state_d;
  logic [IW-1:0]     gnt_q, gnt_d, ptr_q, ptr_d, pick_idx;
  logic              wr_q, wr_d, we_q, we_d, rd_q, rd_d, pick_valid;
  logic [AW-1:0]     addr_q, addr_d;
  logic [15:0]       din_q, din_d, dout_q, dout_d;
  logic [1:0]        wtbt_q, wtbt_d;
  logic [NPORTS-1:0] ack_q, ack_d;
  sdram_rr_pick #(.NPORTS(NPORTS)) u_pick (
    .req  (p_req),
    .ptr  (ptr_q),
    .prio0(PRIO0 != 0),
    .valid(pick_valid),
    .idx  (pick_idx)
  );
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    din_d   = din_q;
    wtbt_d  = wtbt_q;
    dout_d  = dout_q;
    we_d    = 1'b0;
    rd_d    = 1'b0;
    ack_d   = '0;
    case (state_q)
      // no grant in the ack cycle: the acked port may still show req high until it sees the ack
      ST_IDLE: if (pick_valid && mem_ready && !(|ack_q)) begin
        state_d = ST_WAIT_LO;
        gnt_d   = pick_idx;
        wr_d    = p_we[pick_idx];
        we_d    = p_we[pick_idx];
        rd_d    = !p_we[pick_idx];
        addr_d  = p_addr[pick_idx*AW +: AW];
        din_d   = p_din[pick_idx*16 +: 16];
        wtbt_d  = p_wtbt[pick_idx*2 +: 2];
      end
      ST_WAIT_LO: state_d = mem_ready ? ST_WAIT_LO : ST_WAIT_HI;
      ST_WAIT_HI: if (mem_ready) begin
        state_d      = ST_IDLE;
        ack_d[gnt_q] = 1'b1;
        ptr_d        = IW'(rr_next(3'(gnt_q), NPORTS));
        dout_d       = wr_q ? dout_q : mem_dout;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      wr_q    <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      wtbt_q  <= '0;
      dout_q  <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wtbt_q  <= wtbt_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
    end
  end
  assign p_dout   = dout_q;
  assign p_ack    = ack_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign mem_wtbt = wtbt_q;
  assign mem_we   = we_q;
  assign mem_rd   = rd_q;
endmodule
